// File: rtl/clock_set_controller.sv
// Purpose : mode sequencer for the clock; turns debounced Mode/Inc release pulses into
//           RUN / SET_HOURS / SET_MINUTES stepping, counter increment/clear pulses and
//           the blink mask for the digit being edited.
// Latency : one cycle; every output is registered and reflects the edge that samples the input.
// Backpressure: none; every high cycle of an input pulse is consumed as one event.
//
// Ports:
//   i_Clock          system clock, rising edge
//   i_Reset          synchronous active-high reset (priority over all inputs)
//   i_Mode_Released  Mode button release pulse
//   i_Inc_Released   Inc button release pulse
//   o_Run            high in RUN (enables seconds counting)
//   o_Inc_Hours      one-cycle hours +1 command
//   o_Inc_Minutes    one-cycle minutes +1 command
//   o_Clear_Seconds  one-cycle seconds clear, issued when leaving SET_MINUTES via Mode
//   o_Hide_Hours     blank hour digits (blink off phase in SET_HOURS)
//   o_Hide_Minutes   blank minute digits (blink off phase in SET_MINUTES)
//
// Optional build macro CLOCK_SET_TIMEOUT_EN: adds an inactivity timeout that returns to RUN
// after TIMEOUT_BLINKS blink half-periods without a button pulse (no seconds clear).

module clock_set_controller #(
   parameter int BLINK_CYCLES   = 50_000_000,
   parameter int TIMEOUT_BLINKS = 20
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Mode_Released,
   input  logic i_Inc_Released,
   output logic o_Run,
   output logic o_Inc_Hours,
   output logic o_Inc_Minutes,
   output logic o_Clear_Seconds,
   output logic o_Hide_Hours,
   output logic o_Hide_Minutes
);

   localparam int                BLINK_W    = $clog2(BLINK_CYCLES);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      SET_HOURS   = 2'd1,
      SET_MINUTES = 2'd2,
      ILLEGAL     = 2'd3
   } state_t;

   state_t               r_State;
   logic [BLINK_W-1:0]   r_Blink_Cnt;
   logic                 r_Phase_Hidden;

   state_t               w_Next_State;
   logic                 w_Inc_Hours;
   logic                 w_Inc_Minutes;
   logic                 w_Clear_Seconds;
   logic                 w_Inc_Accepted;
   logic                 w_Next_In_Set;
   logic                 w_Blink_Wrap;
   logic [BLINK_W-1:0]   w_Next_Blink_Cnt;
   logic                 w_Next_Phase_Hidden;
   logic                 w_Timeout_Hit;

`ifdef CLOCK_SET_TIMEOUT_EN
   localparam int                  TO_W    = $clog2(TIMEOUT_BLINKS + 1);
   localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT_BLINKS);

   logic [TO_W-1:0] r_Timeout_Cnt;
   logic [TO_W-1:0] w_Next_Timeout_Cnt;

   // A timeout only fires on a quiet cycle; any button pulse takes the normal path instead.
   assign w_Timeout_Hit = ((r_State == SET_HOURS) || (r_State == SET_MINUTES)) &&
                          !i_Mode_Released && !i_Inc_Released &&
                          (r_Timeout_Cnt == TO_LAST);
`else
   logic w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = (TIMEOUT_BLINKS > 0);
   assign w_Timeout_Hit        = 1'b0;
`endif

   // Next-state and command decode. Mode is checked before Inc so a simultaneous
   // press steps the mode and drops the increment.
   always_comb begin
      w_Next_State    = r_State;
      w_Inc_Hours     = 1'b0;
      w_Inc_Minutes   = 1'b0;
      w_Clear_Seconds = 1'b0;
      w_Inc_Accepted  = 1'b0;
      case (r_State)
         RUN: begin
            if (i_Mode_Released) w_Next_State = SET_HOURS;
         end
         SET_HOURS: begin
            if (i_Mode_Released) begin
               w_Next_State = SET_MINUTES;
            end else if (i_Inc_Released) begin
               w_Inc_Hours    = 1'b1;
               w_Inc_Accepted = 1'b1;
            end
         end
         SET_MINUTES: begin
            if (i_Mode_Released) begin
               w_Next_State    = RUN;
               w_Clear_Seconds = 1'b1;
            end else if (i_Inc_Released) begin
               w_Inc_Minutes  = 1'b1;
               w_Inc_Accepted = 1'b1;
            end
         end
         default: begin
            w_Next_State = RUN;
         end
      endcase
      if (w_Timeout_Hit) w_Next_State = RUN;
   end

   // Blink timing. Entering a SET state or accepting an Inc restarts the visible
   // half-period so the edited digits stay lit while the user is stepping them.
   always_comb begin
      w_Next_In_Set       = (w_Next_State == SET_HOURS) || (w_Next_State == SET_MINUTES);
      w_Next_Blink_Cnt    = r_Blink_Cnt;
      w_Next_Phase_Hidden = r_Phase_Hidden;
      w_Blink_Wrap        = 1'b0;
      if (!w_Next_In_Set) begin
         w_Next_Blink_Cnt    = '0;
         w_Next_Phase_Hidden = 1'b0;
      end else if ((w_Next_State != r_State) || w_Inc_Accepted) begin
         w_Next_Blink_Cnt    = '0;
         w_Next_Phase_Hidden = 1'b0;
      end else if (r_Blink_Cnt == BLINK_LAST) begin
         w_Next_Blink_Cnt    = '0;
         w_Next_Phase_Hidden = ~r_Phase_Hidden;
         w_Blink_Wrap        = 1'b1;
      end else begin
         w_Next_Blink_Cnt    = r_Blink_Cnt + 1'b1;
      end
   end

`ifdef CLOCK_SET_TIMEOUT_EN
   always_comb begin
      w_Next_Timeout_Cnt = r_Timeout_Cnt;
      if (i_Mode_Released || i_Inc_Released || (w_Next_State != r_State) || !w_Next_In_Set) begin
         w_Next_Timeout_Cnt = '0;
      end else if (w_Blink_Wrap) begin
         w_Next_Timeout_Cnt = r_Timeout_Cnt + 1'b1;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) r_Timeout_Cnt <= '0;
      else         r_Timeout_Cnt <= w_Next_Timeout_Cnt;
   end
`endif

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_State         <= RUN;
         r_Blink_Cnt     <= '0;
         r_Phase_Hidden  <= 1'b0;
         o_Run           <= 1'b1;
         o_Inc_Hours     <= 1'b0;
         o_Inc_Minutes   <= 1'b0;
         o_Clear_Seconds <= 1'b0;
         o_Hide_Hours    <= 1'b0;
         o_Hide_Minutes  <= 1'b0;
      end else begin
         r_State         <= w_Next_State;
         r_Blink_Cnt     <= w_Next_Blink_Cnt;
         r_Phase_Hidden  <= w_Next_Phase_Hidden;
         o_Run           <= (w_Next_State == RUN);
         o_Inc_Hours     <= w_Inc_Hours;
         o_Inc_Minutes   <= w_Inc_Minutes;
         o_Clear_Seconds <= w_Clear_Seconds;
         o_Hide_Hours    <= (w_Next_State == SET_HOURS) && w_Next_Phase_Hidden;
         o_Hide_Minutes  <= (w_Next_State == SET_MINUTES) && w_Next_Phase_Hidden;
      end
   end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller with BLINK_CYCLES = 8, TIMEOUT_BLINKS = 4.
// Vector records {reset, mode, inc, expected outputs} are queued per scenario, applied one
// per clock, and the expected word is pushed to a scoreboard queue and popped after the edge.

module tb_clock_set_controller;

   localparam int BLINK = 8;

   // Expected output word: {run, inc_h, inc_m, clr_s, hide_h, hide_m}
   localparam logic [5:0] E_RUN = 6'b100000;
   localparam logic [5:0] E_IH  = 6'b010000;
   localparam logic [5:0] E_IM  = 6'b001000;
   localparam logic [5:0] E_CS  = 6'b000100;
   localparam logic [5:0] E_HH  = 6'b000010;
   localparam logic [5:0] E_HM  = 6'b000001;
   localparam logic [5:0] E_SET = 6'b000000;

   typedef struct {
      logic       rst;
      logic       mode;
      logic       inc;
      logic [5:0] exp;
   } vec_t;

   logic clk;
   logic i_Reset, i_Mode_Released, i_Inc_Released;
   logic o_Run, o_Inc_Hours, o_Inc_Minutes, o_Clear_Seconds, o_Hide_Hours, o_Hide_Minutes;

   vec_t       vq[$];
   logic [5:0] exp_q[$];
   int         tests = 0;
   int         fails = 0;

   clock_set_controller #(
      .BLINK_CYCLES   (8),
      .TIMEOUT_BLINKS (4)
   ) dut (
      .i_Clock         (clk),
      .i_Reset         (i_Reset),
      .i_Mode_Released (i_Mode_Released),
      .i_Inc_Released  (i_Inc_Released),
      .o_Run           (o_Run),
      .o_Inc_Hours     (o_Inc_Hours),
      .o_Inc_Minutes   (o_Inc_Minutes),
      .o_Clear_Seconds (o_Clear_Seconds),
      .o_Hide_Hours    (o_Hide_Hours),
      .o_Hide_Minutes  (o_Hide_Minutes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic m, input logic i, input logic [5:0] e);
      vec_t v;
      v.rst  = r;
      v.mode = m;
      v.inc  = i;
      v.exp  = e;
      vq.push_back(v);
   endtask

   task automatic add_idle(input int n, input logic [5:0] e);
      for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0, e);
   endtask

   // Expected hour-blink mask k edges after entering SET_HOURS with no further input.
   function automatic logic [5:0] hh_at(input int k);
      return (((k / BLINK) % 2) == 1) ? E_HH : E_SET;
   endfunction

   task automatic run_vecs(input string name);
      logic [5:0] got;
      logic [5:0] e;
      for (int k = 0; k < vq.size(); k++) begin
         i_Reset         = vq[k].rst;
         i_Mode_Released = vq[k].mode;
         i_Inc_Released  = vq[k].inc;
         exp_q.push_back(vq[k].exp);
         @(posedge clk);
         #1;
         i_Reset         = 1'b0;
         i_Mode_Released = 1'b0;
         i_Inc_Released  = 1'b0;
         got = {o_Run, o_Inc_Hours, o_Inc_Minutes, o_Clear_Seconds, o_Hide_Hours, o_Hide_Minutes};
         e   = exp_q.pop_front();
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL %s[%0d] run/ih/im/cs/hh/hm got %b expected %b", name, k, got, e);
         end
      end
      vq.delete();
   endtask

   initial begin
      i_Reset         = 1'b0;
      i_Mode_Released = 1'b0;
      i_Inc_Released  = 1'b0;
      @(negedge clk);

      // Reset held three cycles, then Inc in RUN must be ignored.
      add(1'b1, 1'b0, 1'b0, E_RUN);
      add(1'b1, 1'b0, 1'b0, E_RUN);
      add(1'b1, 1'b0, 1'b0, E_RUN);
      add_idle(1, E_RUN);
      add(1'b0, 1'b0, 1'b1, E_RUN);
      add_idle(2, E_RUN);
      run_vecs("reset");

      // Full cycle: Mode, Inc x3, Mode, Inc x2, Mode with pulses 5 cycles apart.
      add(1'b0, 1'b1, 1'b0, E_SET);
      add_idle(4, E_SET);
      for (int n = 0; n < 3; n++) begin
         add(1'b0, 1'b0, 1'b1, E_IH);
         add_idle(4, E_SET);
      end
      add(1'b0, 1'b1, 1'b0, E_SET);
      add_idle(4, E_SET);
      for (int n = 0; n < 2; n++) begin
         add(1'b0, 1'b0, 1'b1, E_IM);
         add_idle(4, E_SET);
      end
      add(1'b0, 1'b1, 1'b0, E_RUN | E_CS);
      add_idle(3, E_RUN);
      run_vecs("full_cycle");

      // Blink in SET_HOURS with no activity; timeout (if built in) lands on edge 33.
      add(1'b1, 1'b0, 1'b0, E_RUN);
      add(1'b0, 1'b1, 1'b0, E_SET);
      for (int k = 1; k <= 32; k++) add(1'b0, 1'b0, 1'b0, hh_at(k));
`ifdef CLOCK_SET_TIMEOUT_EN
      add_idle(3, E_RUN);
`else
      for (int k = 33; k <= 233; k++) add(1'b0, 1'b0, 1'b0, hh_at(k));
`endif
      run_vecs("blink_idle");

      // Inc at edge 12 restarts the visible phase for a full half-period.
      add(1'b1, 1'b0, 1'b0, E_RUN);
      add(1'b0, 1'b1, 1'b0, E_SET);
      add_idle(7, E_SET);
      add_idle(4, E_HH);
      add(1'b0, 1'b0, 1'b1, E_IH);
      add_idle(7, E_SET);
      add_idle(2, E_HH);
      run_vecs("blink_inc");

      // Simultaneous Mode+Inc in SET_HOURS: mode steps, increment dropped.
      add(1'b1, 1'b0, 1'b0, E_RUN);
      add(1'b0, 1'b1, 1'b0, E_SET);
      add(1'b0, 1'b1, 1'b1, E_SET);
      add(1'b0, 1'b0, 1'b1, E_IM);
      add(1'b0, 1'b1, 1'b0, E_RUN | E_CS);
      run_vecs("simultaneous");

      // Reset while minutes are hidden, with Mode also high: reset wins, no seconds clear.
      add(1'b1, 1'b0, 1'b0, E_RUN);
      add(1'b0, 1'b1, 1'b0, E_SET);
      add(1'b0, 1'b1, 1'b0, E_SET);
      add_idle(7, E_SET);
      add_idle(1, E_HM);
      add(1'b1, 1'b1, 1'b0, E_RUN);
      add_idle(2, E_RUN);
      run_vecs("reset_mid");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
